// File: rtl/riscv_debug_loader.sv
`default_nettype none
// ============================================================================
// Module      : riscv_debug_loader
// Description : Framed byte-stream loader that holds the core in debug mode
//               and writes word pairs into instruction or data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_debug_loader #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  enable_debug,
    output logic [DM_ADDRESS-1:0] DebugAddress,
    output logic [DATA_W-1:0]     DebugData1,
    output logic [DATA_W-1:0]     DebugData2,
    output logic [DM_ADDRESS-1:0] debug_inst_addr,
    output logic [DATA_W-1:0]     debug_inst_data1,
    output logic [DATA_W-1:0]     debug_inst_data2,
    output logic                  dm_we,
    output logic                  im_we,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CNT_LO = 3'd1;
    localparam logic [2:0] c_ST_CNT_HI = 3'd2;
    localparam logic [2:0] c_ST_WORD   = 3'd3;
    localparam logic [2:0] c_ST_WRITE  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    localparam logic [7:0]  c_TGT_IMEM  = 8'h49;
    localparam logic [7:0]  c_TGT_DMEM  = 8'h44;
    // Largest word count whose pairs still fit the pair address space.
    localparam logic [16:0] c_MAX_WORDS = 17'(2 ** (DM_ADDRESS + 1));

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  r_is_imem;
    logic [7:0]            r_cnt_lo;
    logic [16:0]           r_count;
    logic [16:0]           r_word_cnt;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_shift;
    logic [DATA_W-1:0]     r_even;
    logic [DM_ADDRESS-1:0] r_pair_addr;

    logic [DM_ADDRESS-1:0] r_dm_addr;
    logic [DATA_W-1:0]     r_dm_data1;
    logic [DATA_W-1:0]     r_dm_data2;
    logic [DM_ADDRESS-1:0] r_im_addr;
    logic [DATA_W-1:0]     r_im_data1;
    logic [DATA_W-1:0]     r_im_data2;

    logic                  w_accept;
    logic [16:0]           w_count_full;
    logic [DATA_W-1:0]     w_word;
    logic                  w_word_done;
    logic                  w_is_odd;
    logic                  w_last_word;
    logic                  w_pair_ready;
    logic [DATA_W-1:0]     w_pair_d1;
    logic [DATA_W-1:0]     w_pair_d2;

    assign w_accept     = in_valid & in_ready;
    assign w_count_full = {1'b0, in_data, r_cnt_lo};
    assign w_word       = {in_data, r_shift};
    assign w_word_done  = (r_state == c_ST_WORD) && w_accept && (r_byte_cnt == 2'd3);
    assign w_is_odd     = r_word_cnt[0];
    assign w_last_word  = (r_word_cnt == (r_count - 17'd1));
    assign w_pair_ready = w_word_done && (w_is_odd || w_last_word);
    // An odd word closes a pair; a trailing even word is paired with zero.
    assign w_pair_d1    = w_is_odd ? r_even : w_word;
    assign w_pair_d2    = w_is_odd ? w_word : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        enable_debug = 1'b1;
        load_done    = 1'b0;
        load_err     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                in_ready     = 1'b1;
                enable_debug = 1'b0;
                if (w_accept) begin
                    if ((in_data == c_TGT_IMEM) || (in_data == c_TGT_DMEM)) begin
                        w_state_nxt = c_ST_CNT_LO;
                    end else begin
                        w_state_nxt = c_ST_ERR;
                    end
                end
            end
            c_ST_CNT_LO: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = c_ST_CNT_HI;
                end
            end
            c_ST_CNT_HI: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (w_count_full == 17'd0) begin
                        w_state_nxt = c_ST_DONE;
                    end else if (w_count_full > c_MAX_WORDS) begin
                        w_state_nxt = c_ST_ERR;
                    end else begin
                        w_state_nxt = c_ST_WORD;
                    end
                end
            end
            c_ST_WORD: begin
                in_ready = 1'b1;
                if (w_pair_ready) begin
                    w_state_nxt = c_ST_WRITE;
                end
            end
            c_ST_WRITE: begin
                w_state_nxt = (r_word_cnt != r_count) ? c_ST_WORD : c_ST_DONE;
            end
            c_ST_DONE: begin
                load_done   = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_ERR: begin
                load_err    = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_imem   <= 1'b0;
            r_cnt_lo    <= '0;
            r_count     <= '0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_even      <= '0;
            r_pair_addr <= '0;
            r_dm_addr   <= '0;
            r_dm_data1  <= '0;
            r_dm_data2  <= '0;
            r_im_addr   <= '0;
            r_im_data1  <= '0;
            r_im_data2  <= '0;
        end else if (w_accept) begin
            case (r_state)
                c_ST_IDLE: begin
                    r_is_imem   <= (in_data == c_TGT_IMEM);
                    r_word_cnt  <= '0;
                    r_byte_cnt  <= '0;
                    r_pair_addr <= '0;
                end
                c_ST_CNT_LO: r_cnt_lo <= in_data;
                c_ST_CNT_HI: r_count  <= w_count_full;
                c_ST_WORD: begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_shift    <= {in_data, r_shift[23:8]};
                    if (w_word_done) begin
                        r_word_cnt <= r_word_cnt + 17'd1;
                        if (!w_is_odd) begin
                            r_even <= w_word;
                        end
                    end
                    // Outputs are loaded here so they are valid during the strobe cycle.
                    if (w_pair_ready) begin
                        r_pair_addr <= r_pair_addr + 1'b1;
                        if (r_is_imem) begin
                            r_im_addr  <= r_pair_addr;
                            r_im_data1 <= w_pair_d1;
                            r_im_data2 <= w_pair_d2;
                        end else begin
                            r_dm_addr  <= r_pair_addr;
                            r_dm_data1 <= w_pair_d1;
                            r_dm_data2 <= w_pair_d2;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dm_we            = (r_state == c_ST_WRITE) && !r_is_imem;
    assign im_we            = (r_state == c_ST_WRITE) &&  r_is_imem;
    assign DebugAddress     = r_dm_addr;
    assign DebugData1       = r_dm_data1;
    assign DebugData2       = r_dm_data2;
    assign debug_inst_addr  = r_im_addr;
    assign debug_inst_data1 = r_im_data1;
    assign debug_inst_data2 = r_im_data2;

endmodule
`default_nettype wire

// File: tb/tb_riscv_debug_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_debug_loader
// Description : Randomized self-checking bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_debug_loader;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          enable_debug;
    logic [AW-1:0] DebugAddress;
    logic [DW-1:0] DebugData1;
    logic [DW-1:0] DebugData2;
    logic [AW-1:0] debug_inst_addr;
    logic [DW-1:0] debug_inst_data1;
    logic [DW-1:0] debug_inst_data2;
    logic          dm_we;
    logic          im_we;
    logic          load_done;
    logic          load_err;

    riscv_debug_loader #(.DATA_W(DW), .DM_ADDRESS(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .enable_debug     (enable_debug),
        .DebugAddress     (DebugAddress),
        .DebugData1       (DebugData1),
        .DebugData2       (DebugData2),
        .debug_inst_addr  (debug_inst_addr),
        .debug_inst_data1 (debug_inst_data1),
        .debug_inst_data2 (debug_inst_data2),
        .dm_we            (dm_we),
        .im_we            (im_we),
        .load_done        (load_done),
        .load_err         (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            imem;
        logic [AW-1:0] addr;
        logic [31:0]   d1;
        logic [31:0]   d2;
    } wr_t;

    int  checks   = 0;
    int  failures = 0;
    wr_t q_wr[$];
    bit  q_out[$];
    wr_t m_wr[$];
    bit  stall_en = 1'b0;

    logic [AW-1:0] e_dm_addr, e_im_addr;
    logic [31:0]   e_dm1, e_dm2, e_im1, e_im2;
    bit            busy;
    int            cycle;
    int            last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wr_t mk_wr(input bit imem, input int addr, input logic [31:0] d1, input logic [31:0] d2);
        wr_t w;
        w.imem = imem;
        w.addr = AW'(addr);
        w.d1   = d1;
        w.d2   = d2;
        return w;
    endfunction

    // Reference model: whole frame -> list of pair writes and done/err outcome.
    function automatic bit model_frame(input logic [7:0] tgt, input int n, input logic [31:0] words[$]);
        m_wr.delete();
        if (tgt != 8'h49 && tgt != 8'h44) return 1'b0;
        if (n > (1 << (AW + 1))) return 1'b0;
        for (int k = 0; 2 * k < n; k++) begin
            m_wr.push_back(mk_wr(tgt == 8'h49, k, words[2 * k],
                                 (2 * k + 1 < n) ? words[2 * k + 1] : 32'h0));
        end
        return 1'b1;
    endfunction

    // Monitor: outputs after posedge k are compared at negedge k.
    initial begin
        wr_t w;
        busy = 0; cycle = 0; last_acc = -10;
        e_dm_addr = '0; e_im_addr = '0;
        e_dm1 = '0; e_dm2 = '0; e_im1 = '0; e_im2 = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (dm_we || im_we) begin
                chk("single_strobe", 64'(dm_we && im_we), 64'd0);
                chk("strobe_latency", 64'(last_acc), 64'(cycle - 1));
                if (q_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=dm%0d/im%0d required=none", dm_we, im_we);
                end else begin
                    w = q_wr.pop_front();
                    chk("write_target", 64'(im_we), 64'(w.imem));
                    if (w.imem) begin
                        e_im_addr = w.addr; e_im1 = w.d1; e_im2 = w.d2;
                    end else begin
                        e_dm_addr = w.addr; e_dm1 = w.d1; e_dm2 = w.d2;
                    end
                end
            end
            if (load_done || load_err) begin
                chk("pulse_exclusive", 64'(load_done && load_err), 64'd0);
                if (q_out.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_outcome actual=done%0d/err%0d required=none", load_done, load_err);
                end else begin
                    chk("outcome_done", 64'(load_done), 64'(q_out.pop_front()));
                end
            end
            chk("in_ready", 64'(in_ready), 64'(!(dm_we || im_we || load_done || load_err)));
            chk("enable_debug", 64'(enable_debug), 64'(busy));
            chk("DebugAddress", 64'(DebugAddress), 64'(e_dm_addr));
            chk("DebugData1", 64'(DebugData1), 64'(e_dm1));
            chk("DebugData2", 64'(DebugData2), 64'(e_dm2));
            chk("debug_inst_addr", 64'(debug_inst_addr), 64'(e_im_addr));
            chk("debug_inst_data1", 64'(debug_inst_data1), 64'(e_im1));
            chk("debug_inst_data2", 64'(debug_inst_data2), 64'(e_im2));
            if (reset) begin
                busy = 0;
                e_dm_addr = '0; e_im_addr = '0;
                e_dm1 = '0; e_dm2 = '0; e_im1 = '0; e_im2 = '0;
                q_wr.delete();
                q_out.delete();
            end else begin
                if (in_valid && in_ready) last_acc = cycle;
                if (load_done || load_err) busy = 0;
                else if (in_valid && in_ready) busy = 1;
            end
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        if (stall_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t > 50) begin
                checks++; failures++;
                $display("FAIL accept_timeout actual=in_ready0 required=in_ready1 byte=%0h", b);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] tgt, input int n, input logic [31:0] words[$]);
        logic [15:0] nn;
        logic [31:0] w;
        nn = 16'(n);
        send_byte(tgt);
        if (tgt == 8'h49 || tgt == 8'h44) begin
            send_byte(nn[7:0]);
            send_byte(nn[15:8]);
            if (n > 0 && n <= (1 << (AW + 1))) begin
                for (int i = 0; i < n; i++) begin
                    w = words[i];
                    send_byte(w[7:0]);
                    send_byte(w[15:8]);
                    send_byte(w[23:16]);
                    send_byte(w[31:24]);
                end
            end
        end
    endtask

    task automatic wait_outcome();
        int t;
        t = 0;
        while (q_out.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q_out.size() > 0) begin
            checks++; failures++;
            $display("FAIL outcome_timeout actual=none required=%0d pending", q_out.size());
            q_out.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic gen_and_run(input logic [7:0] tgt, input int n, input bit stall);
        logic [31:0] words[$];
        bit ok;
        for (int i = 0; i < n && i <= (1 << (AW + 1)); i++) words.push_back($urandom);
        ok = model_frame(tgt, n, words);
        foreach (m_wr[i]) q_wr.push_back(m_wr[i]);
        q_out.push_back(ok);
        stall_en = stall;
        send_frame(tgt, n, words);
        wait_outcome();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] words[$];
        bit ok;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_enable_debug", 64'(enable_debug), 64'd0);
        chk("rst_strobes", 64'({dm_we, im_we, load_done, load_err}), 64'd0);
        @(posedge clk); #1;

        // Instruction frame 49 02 00 | 13 00 00 00 | 93 00 10 00
        words = '{32'h00000013, 32'h00100093};
        ok = model_frame(8'h49, 2, words);
        chk("model_pin_ok", 64'(ok), 64'd1);
        chk("model_pin_count", 64'(m_wr.size()), 64'd1);
        chk("model_pin_d2", 64'(m_wr[0].d2), 64'h00100093);
        q_wr.push_back(mk_wr(1'b1, 0, 32'h00000013, 32'h00100093));
        q_out.push_back(1'b1);
        stall_en = 1'b0;
        send_frame(8'h49, 2, words);
        wait_outcome();

        // Data frame N=3, trailing odd word paired with zero
        words = '{32'h11111111, 32'h22222222, 32'h33333333};
        ok = model_frame(8'h44, 3, words);
        chk("model_pin3_count", 64'(m_wr.size()), 64'd2);
        chk("model_pin3_addr", 64'(m_wr[1].addr), 64'd1);
        chk("model_pin3_d2", 64'(m_wr[1].d2), 64'd0);
        q_wr.push_back(mk_wr(1'b0, 0, 32'h11111111, 32'h22222222));
        q_wr.push_back(mk_wr(1'b0, 1, 32'h33333333, 32'h00000000));
        q_out.push_back(1'b1);
        send_frame(8'h44, 3, words);
        wait_outcome();

        gen_and_run(8'h55, 0, 1'b0);                // bad target
        gen_and_run(8'h44, 0, 1'b0);                // empty frame
        gen_and_run(8'h44, 16'h0401, 1'b0);         // one word too many
        gen_and_run(8'h49, 4, 1'b1);                // stalled 4-word frame
        for (int i = 0; i < 8; i++) begin
            gen_and_run(($urandom_range(0, 1) != 0) ? 8'h49 : 8'h44,
                        int'($urandom_range(1, 9)), ($urandom_range(0, 1) != 0));
        end
        gen_and_run(8'h49, 1 << (AW + 1), 1'b0);   // largest legal frame

        // Reset in the middle of the first word of a data frame
        stall_en = 1'b0;
        send_byte(8'h44);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'hAB);
        send_byte(8'hCD);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_enable_debug", 64'(enable_debug), 64'd0);
        chk("midrst_strobes", 64'({dm_we, im_we, load_done, load_err}), 64'd0);
        chk("midrst_dm", 64'({DebugAddress, DebugData1[15:0]}), 64'd0);
        chk("midrst_im", 64'({debug_inst_addr, debug_inst_data1[15:0]}), 64'd0);
        @(posedge clk); #1;
        gen_and_run(8'h44, 4, 1'b1);
        gen_and_run(8'h49, 3, 1'b0);

        repeat (3) @(negedge clk);
        chk("leftover_writes", 64'(q_wr.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
